// File: rtl/grn_drain_pkg.sv
// grn_drain_pkg: shared state encoding and sizing helpers for the result drainer.
package grn_drain_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_WAIT_LAST, S_DONE} state_t;
  function automatic int rpw_f(input int dw, input int ow);
    return ow / dw;
  endfunction
  function automatic int slot_w_f(input int rpw);
    return rpw > 1 ? $clog2(rpw) : 1;
  endfunction
endpackage

// File: rtl/grn_word_packer.sv
// grn_word_packer: accumulates result words into slots of one host-width pack register.
module grn_word_packer
  import grn_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 246,
  parameter int OUT_WIDTH  = 512,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [OUT_WIDTH-1:0]  word
);
  localparam int RPW = rpw_f(DATA_WIDTH, OUT_WIDTH);
  localparam int SW  = slot_w_f(RPW);
  logic [RPW*DATA_WIDTH-1:0] r_word;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [SW-1:0]             w_slot;
  assign w_slot = SW'(r_cnt);
  assign full   = r_cnt == CNT_WIDTH'(RPW);
  assign count  = r_cnt;
  assign word   = OUT_WIDTH'(r_word);
  // clearing on every hand-off keeps unused slots zero in a partial terminal word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (wr_en) begin
      r_word[int'(w_slot)*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/grn_result_drainer.sv
// grn_result_drainer: drains a regulator result FIFO into a packed valid/ready stream.
// Define GRN_DRAIN_COUNT_EN to enable the 32-bit results_count counter.
module grn_result_drainer
  import grn_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 246,
  parameter int OUT_WIDTH  = 512,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  has_data_out,
  input  logic                  has_lst3_data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  task_done,
  output logic                  read_data_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_last,
  output logic                  done,
  output logic [31:0]           results_count
);
  localparam int RPW = rpw_f(DATA_WIDTH, OUT_WIDTH);
  state_t                 r_state;
  logic                   r_inflight;
  logic                   r_done_seen;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic                   r_done;
  logic [OUT_WIDTH-1:0]   r_out_data;
  logic [CNT_WIDTH-1:0]   r_out_count;
  logic                   w_pk_full;
  logic [CNT_WIDTH-1:0]   w_pk_count;
  logic [OUT_WIDTH-1:0]   w_pk_word;
  logic                   w_start_ok;
  logic                   w_out_free;
  logic                   w_handoff;
  logic                   w_flush_load;
  logic [31:0]            w_pend;
  assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_out_free   = !r_out_valid || out_ready;
  assign w_handoff    = r_state == S_RUN && w_pk_full && w_out_free;
  assign w_flush_load = r_state == S_FLUSH && w_out_free;
  // a slot freed by this cycle's hand-off may already be claimed by a new read
  assign w_pend       = (w_handoff ? 32'd0 : 32'(w_pk_count)) + 32'(r_inflight);
  assign read_data_en = r_state == S_RUN && has_data_out && w_pend < 32'(RPW) &&
                        (!has_lst3_data_out || !r_inflight);
  grn_word_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_start_ok || w_handoff || w_flush_load),
    .wr_en  (r_inflight),
    .wr_data(data_in),
    .full   (w_pk_full),
    .count  (w_pk_count),
    .word   (w_pk_word)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_inflight  <= 1'b0;
      r_done_seen <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      r_inflight <= read_data_en;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_handoff || w_flush_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pk_word;
        r_out_count <= w_handoff ? CNT_WIDTH'(RPW) : w_pk_count;
        r_out_last  <= w_flush_load;
      end
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state     <= S_RUN;
          r_done_seen <= 1'b0;
          r_done      <= 1'b0;
        end
        S_RUN: begin
          r_done_seen <= r_done_seen || task_done;
          if (r_done_seen && !has_data_out && !r_inflight && !w_pk_full) r_state <= S_FLUSH;
        end
        S_FLUSH: if (w_out_free) r_state <= S_WAIT_LAST;
        S_WAIT_LAST: if (r_out_valid && out_ready) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef GRN_DRAIN_COUNT_EN
  logic [31:0] r_results_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_results_count <= '0;
    else if (w_start_ok) r_results_count <= '0;
    else if (r_inflight) r_results_count <= r_results_count + 32'd1;
  end
  assign results_count = r_results_count;
`else
  assign results_count = '0;
`endif
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_last  = r_out_last;
  assign done      = r_done;
endmodule

// File: tb/tb_grn_result_drainer.sv
// tb_grn_result_drainer: scoreboard bench with a behavioural regulator result FIFO.
module tb_grn_result_drainer;
  localparam int DW = 246;
  localparam int OW = 512;
  localparam int CW = 2;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, task_done = 1'b0, out_ready = 1'b0;
  logic          has_data_out = 1'b0, has_lst3_data_out = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          read_data_en, out_valid, out_last, done;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic [31:0]   results_count;
  typedef struct {logic [OW-1:0] d; logic [CW-1:0] c; logic l;} exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] pend[$];
  int            n_tests = 0, n_fail = 0, rd_cnt = 0, consec_err = 0, nodata_err = 0;
  logic          prev_rd = 1'b0;

  grn_result_drainer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .has_data_out(has_data_out),
    .has_lst3_data_out(has_lst3_data_out), .data_in(data_in), .task_done(task_done),
    .read_data_en(read_data_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_last(out_last), .done(done),
    .results_count(results_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Regulator FIFO model: data appears the cycle after read_data_en.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo.delete();
      pend.delete();
      has_data_out      <= 1'b0;
      has_lst3_data_out <= 1'b1;
      prev_rd           <= 1'b0;
    end else begin
      if (read_data_en) begin
        rd_cnt++;
        if (!has_data_out) nodata_err++;
        if (prev_rd && has_lst3_data_out) consec_err++;
        if (fifo.size() > 0) data_in <= fifo.pop_front();
      end
      prev_rd <= read_data_en;
      while (pend.size() > 0) fifo.push_back(pend.pop_front());
      has_data_out      <= fifo.size() > 0;
      has_lst3_data_out <= fifo.size() <= 2;
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {out_last, out_data}, '0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_count", OW'(out_count), OW'(e.c));
        chk("word_last", OW'(out_last), OW'(e.l));
      end
    end
  end

  function automatic logic [DW-1:0] mk(input int i);
    logic [5:0] b;
    b = 6'(i + 1);
    return {41{b}};
  endfunction
  function automatic logic [OW-1:0] p2(input int i);
    return {{(OW-2*DW){1'b0}}, mk(i + 1), mk(i)};
  endfunction
  function automatic logic [OW-1:0] p1(input int i);
    return {{(OW-DW){1'b0}}, mk(i)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_res(input int base, input int n);
    for (int i = 0; i < n; i++) pend.push_back(mk(base + i));
  endtask
  task automatic expw(input logic [OW-1:0] d, input int c, input logic l);
    exp_q.push_back('{d, CW'(c), l});
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic finish_session(input string nm, input int n_res);
    int k;
    for (k = 0; k < 300; k++) begin
      if (done && exp_q.size() == 0) break;
      cyc(1);
    end
    if (k == 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got done=%0d pending=%0d required done=1 pending=0", nm, done, exp_q.size());
    end
    chk({nm, "_done"}, OW'(done), OW'(1));
`ifdef GRN_DRAIN_COUNT_EN
    chk({nm, "_results_count"}, OW'(results_count), OW'(n_res));
`else
    chk({nm, "_results_count"}, OW'(results_count), OW'(0) + OW'(n_res & 0));
`endif
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, OW'(out_valid), '0);
    chk({nm, "_data"}, out_data, '0);
    chk({nm, "_count"}, OW'(out_count), '0);
    chk({nm, "_last"}, OW'(out_last), '0);
    chk({nm, "_done"}, OW'(done), '0);
    chk({nm, "_rd"}, OW'(read_data_en), '0);
    chk({nm, "_results_count"}, OW'(results_count), '0);
  endtask

  initial begin
    int r0;
    logic [OW-1:0] snap;
    bit seen;
    #2 rst = 1'b0;
    #1 chk_zero("reset");
    #10 rst = 1'b1;
    cyc(2);
    // four results, task_done already high
    out_ready = 1'b1;
    task_done = 1'b1;
    push_res(0, 4);
    expw(p2(0), 2, 1'b0);
    expw(p2(2), 2, 1'b0);
    expw('0, 0, 1'b1);
    cyc(3);
    pulse_start();
    finish_session("t1", 4);
    // three results: partial terminal word
    push_res(10, 3);
    expw(p2(10), 2, 1'b0);
    expw(p1(12), 1, 1'b1);
    cyc(3);
    pulse_start();
    finish_session("t2", 3);
    // single entry while almost empty
    r0 = rd_cnt;
    push_res(20, 1);
    expw(p1(20), 1, 1'b1);
    cyc(3);
    pulse_start();
    finish_session("t3", 1);
    chk("t3_read_pulses", OW'(rd_cnt - r0), OW'(1));
    chk("t3_consecutive_reads", OW'(consec_err), '0);
    // back-pressure with ten results
    task_done = 1'b0;
    out_ready = 1'b0;
    push_res(30, 10);
    cyc(3);
    r0 = rd_cnt;
    pulse_start();
    cyc(5);
    snap = out_data;
    cyc(15);
    chk("t4_stall_valid", OW'(out_valid), OW'(1));
    chk("t4_stall_stable", out_data, snap);
    chk("t4_stall_word", out_data, p2(30));
    chk("t4_stall_reads", OW'(rd_cnt - r0), OW'(4));
    for (int i = 0; i < 5; i++) expw(p2(30 + 2*i), 2, 1'b0);
    expw('0, 0, 1'b1);
    out_ready = 1'b1;
    task_done = 1'b1;
    finish_session("t4", 10);
    // asynchronous reset with a read in flight
    out_ready = 1'b0;
    task_done = 1'b0;
    push_res(50, 5);
    cyc(3);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = read_data_en;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL t5_read_timeout: got no read_data_en required one");
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("t5_reset");
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    push_res(60, 7);
    expw(p2(60), 2, 1'b0);
    expw(p2(62), 2, 1'b0);
    expw(p2(64), 2, 1'b0);
    expw(p1(66), 1, 1'b1);
    task_done = 1'b1;
    out_ready = 1'b1;
    cyc(3);
    pulse_start();
    finish_session("t5", 7);
    chk("no_read_while_empty", OW'(nodata_err), '0);
    chk("no_consecutive_almost_empty", OW'(consec_err), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
